// File: rtl/mini_alu_core_p.sv
// mini_alu_core_p: two-stage fetch/execute micro-sequencer with narrow and wide register files,
// branches, HALT and a signed multiplier. Build option MINI_ALU_FAST_MUL_EN selects a single-cycle multiply.
module mini_alu_core_p #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_AW     = 8,
  parameter int NUM_REGS   = 256,
  parameter int WIDE_AW    = 3,
  parameter int IP_WIDTH   = 16,
  parameter int LED_WIDTH  = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  output logic [IP_WIDTH-1:0]     oIP,
  input  logic [4+3*REG_AW-1:0]   iInstruction,
  output logic [LED_WIDTH-1:0]    oLed,
  output logic                    oBusy,
  output logic                    oHalted
);

  localparam int IW       = 4 + 3*REG_AW;
  localparam int WW       = 2*DATA_WIDTH;
  localparam int NUM_WIDE = 2**WIDE_AW;
  localparam int RIW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [REG_AW:0] NUM_REGS_L = (REG_AW+1)'(NUM_REGS);
  localparam logic [IW-1:0]   NOP_WORD   = '0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LED  = 4'h1;
  localparam logic [3:0] OP_BLE  = 4'h2;
  localparam logic [3:0] OP_STO  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SMUL = 4'h7;
  localparam logic [3:0] OP_ADDW = 4'h8;
  localparam logic [3:0] OP_SUBW = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic in_range(input logic [REG_AW-1:0] addr);
    return ({1'b0, addr} < NUM_REGS_L);
  endfunction

  // Architectural state
  logic [IP_WIDTH-1:0]   ip_q, ip_d;
  logic [IW-1:0]         instr_q, instr_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic                  halted_q, halted_d;
  logic [DATA_WIDTH-1:0] rf_q  [NUM_REGS];
  logic [WW-1:0]         wrf_q [NUM_WIDE];

  // Decode and operand read
  logic [3:0]            op_s;
  logic [REG_AW-1:0]     dest_s, src1_s, src0_s;
  logic [IP_WIDTH-1:0]   target_s;
  logic [DATA_WIDTH-1:0] ra_s, rb_s;
  logic [WW-1:0]         wa_s, wb_s;

  // Writeback ports
  logic                  rf_we_s;
  logic [DATA_WIDTH-1:0] rf_wdata_s;
  logic                  wf_we_s;
  logic [WW-1:0]         wf_wdata_s;

`ifdef MINI_ALU_FAST_MUL_EN
  logic [WW-1:0]         prod_s;
`else
  typedef enum logic [0:0] {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

  mul_state_e            mul_state_q, mul_state_d;
  logic [WW-1:0]         mcand_q, mcand_d;
  logic [WW-1:0]         acc_q, acc_d, acc_sum_s;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic                  busy_q, busy_d;

  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v);
    if (v[DATA_WIDTH-1]) begin
      return ~v + DATA_WIDTH'(1);
    end else begin
      return v;
    end
  endfunction
`endif

  assign op_s     = instr_q[IW-1 -: 4];
  assign dest_s   = instr_q[2*REG_AW +: REG_AW];
  assign src1_s   = instr_q[REG_AW +: REG_AW];
  assign src0_s   = instr_q[0 +: REG_AW];
  assign target_s = IP_WIDTH'(dest_s);

  assign wa_s = wrf_q[src1_s[WIDE_AW-1:0]];
  assign wb_s = wrf_q[src0_s[WIDE_AW-1:0]];

  // Narrow operand read; addresses beyond the implemented file read as zero.
  always_comb begin
    ra_s = '0;
    rb_s = '0;
    if (in_range(src1_s)) begin
      ra_s = rf_q[src1_s[RIW-1:0]];
    end else begin
      ra_s = '0;
    end
    if (in_range(src0_s)) begin
      rb_s = rf_q[src0_s[RIW-1:0]];
    end else begin
      rb_s = '0;
    end
  end

`ifdef MINI_ALU_FAST_MUL_EN
  assign prod_s = $signed({{DATA_WIDTH{ra_s[DATA_WIDTH-1]}}, ra_s})
                * $signed({{DATA_WIDTH{rb_s[DATA_WIDTH-1]}}, rb_s});
`else
  assign acc_sum_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

  // Next-state: fetch advance, execute decode, branch/halt and multiplier sequencing.
  always_comb begin
    ip_d       = ip_q;
    instr_d    = instr_q;
    led_d      = led_q;
    halted_d   = halted_q;
    rf_we_s    = 1'b0;
    rf_wdata_s = '0;
    wf_we_s    = 1'b0;
    wf_wdata_s = '0;
`ifdef MINI_ALU_FAST_MUL_EN
`else
    mul_state_d = mul_state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
`endif
    if (halted_q) begin
      ip_d    = ip_q;
      instr_d = NOP_WORD;
    end else begin
      ip_d    = ip_q + IP_WIDTH'(1);
      instr_d = iInstruction;
      case (op_s)
        OP_NOP: begin
        end
        OP_LED: begin
          led_d = ra_s[LED_WIDTH-1:0];
        end
        OP_BLE: begin
          if (ra_s <= rb_s) begin
            ip_d    = target_s;
            instr_d = NOP_WORD;
          end else begin
            ip_d = ip_q + IP_WIDTH'(1);
          end
        end
        OP_STO: begin
          rf_we_s    = in_range(dest_s);
          rf_wdata_s = DATA_WIDTH'({src1_s, src0_s});
        end
        OP_ADD: begin
          rf_we_s    = in_range(dest_s);
          rf_wdata_s = ra_s + rb_s;
        end
        OP_JMP: begin
          ip_d    = target_s;
          instr_d = NOP_WORD;
        end
        OP_SUB: begin
          rf_we_s    = in_range(dest_s);
          rf_wdata_s = ra_s - rb_s;
        end
        OP_SMUL: begin
`ifdef MINI_ALU_FAST_MUL_EN
          wf_we_s    = 1'b1;
          wf_wdata_s = prod_s;
`else
          // Magnitude shift-add; the sign is reapplied on the final write.
          if (mul_state_q == MUL_IDLE) begin
            mcand_d     = WW'(mag(ra_s));
            mplier_d    = mag(rb_s);
            neg_d       = ra_s[DATA_WIDTH-1] ^ rb_s[DATA_WIDTH-1];
            acc_d       = '0;
            cnt_d       = '0;
            mul_state_d = MUL_RUN;
            ip_d        = ip_q;
            instr_d     = instr_q;
          end else begin
            acc_d    = acc_sum_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH-1)) begin
              wf_we_s     = 1'b1;
              wf_wdata_s  = neg_q ? (~acc_sum_s + WW'(1)) : acc_sum_s;
              mul_state_d = MUL_IDLE;
            end else begin
              ip_d    = ip_q;
              instr_d = instr_q;
            end
          end
`endif
        end
        OP_ADDW: begin
          wf_we_s    = 1'b1;
          wf_wdata_s = wa_s + wb_s;
        end
        OP_SUBW: begin
          wf_we_s    = 1'b1;
          wf_wdata_s = wa_s - wb_s;
        end
        OP_BEQ: begin
          if (ra_s == rb_s) begin
            ip_d    = target_s;
            instr_d = NOP_WORD;
          end else begin
            ip_d = ip_q + IP_WIDTH'(1);
          end
        end
        OP_HALT: begin
          halted_d = 1'b1;
          ip_d     = ip_q;
          instr_d  = NOP_WORD;
        end
        default: begin
        end
      endcase
    end
  end

  // Fetch/execute pipeline registers and architectural outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ip_q     <= '0;
      instr_q  <= NOP_WORD;
      led_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      ip_q     <= ip_d;
      instr_q  <= instr_d;
      led_q    <= led_d;
      halted_q <= halted_d;
    end
  end

  // Register-file writeback; both files clear on reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rf_q  <= '{default: '0};
      wrf_q <= '{default: '0};
    end else begin
      if (rf_we_s) begin
        rf_q[dest_s[RIW-1:0]] <= rf_wdata_s;
      end
      if (wf_we_s) begin
        wrf_q[dest_s[WIDE_AW-1:0]] <= wf_wdata_s;
      end
    end
  end

`ifdef MINI_ALU_FAST_MUL_EN
  assign oBusy = 1'b0;
`else
  // Busy is high for every cycle a SMUL sits in the execute register.
  assign busy_d = (instr_d[IW-1 -: 4] == OP_SMUL);

  // Iterative multiplier state; reset aborts any operation in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mul_state_q <= MUL_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mul_state_q <= mul_state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      busy_q      <= busy_d;
    end
  end

  assign oBusy = busy_q;
`endif

  assign oIP     = ip_q;
  assign oLed    = led_q;
  assign oHalted = halted_q;

endmodule

// File: tb/tb_mini_alu_core_p.sv
// Self-checking bench for mini_alu_core_p: behavioural ROM, LED scoreboard and per-feature test tasks.
`timescale 1ns/1ps
module tb_mini_alu_core_p;

  localparam int LW   = 8;
  localparam int IPW  = 16;
  localparam int IW   = 4 + 3*8;
  localparam int IW2  = 4 + 3*9;
`ifdef MINI_ALU_FAST_MUL_EN
  localparam int SMUL_BUSY = 0;
`else
  localparam int SMUL_BUSY = 17;
`endif

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic [IPW-1:0]  oIP, oIP2;
  logic [IW-1:0]   iInstruction;
  logic [IW2-1:0]  iInstruction2;
  logic [LW-1:0]   oLed, oLed2;
  logic            oBusy, oBusy2, oHalted, oHalted2;

  logic [IW-1:0]   rom  [256];
  logic [IW2-1:0]  rom2 [256];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [LW-1:0]  exp_led_q[$], obs_led_q[$], exp_led2_q[$], obs_led2_q[$];
  logic [IPW-1:0] ip_trace_q[$];
  logic [LW-1:0]  led_prev, led2_prev;
  logic [IPW-1:0] busy_ip;
  logic           busy_seen, busy_ip_moved, timed_out;
  int             busy_cycles, halt_cycles;

  always #5 Clock = ~Clock;

  assign iInstruction  = rom[oIP[7:0]];
  assign iInstruction2 = rom2[oIP2[7:0]];

  mini_alu_core_p dut (
    .Clock(Clock), .Reset(Reset), .oIP(oIP), .iInstruction(iInstruction),
    .oLed(oLed), .oBusy(oBusy), .oHalted(oHalted)
  );

  mini_alu_core_p #(.REG_AW(9), .NUM_REGS(256)) dut2 (
    .Clock(Clock), .Reset(Reset), .oIP(oIP2), .iInstruction(iInstruction2),
    .oLed(oLed2), .oBusy(oBusy2), .oHalted(oHalted2)
  );

  function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [7:0] d, input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [IW-1:0] sto(input logic [7:0] d, input logic [15:0] v);
    return {4'h3, d, v};
  endfunction

  function automatic logic [IW2-1:0] ins2(input logic [3:0] op, input logic [8:0] d, input logic [8:0] s1, input logic [8:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [IW2-1:0] sto2(input logic [8:0] d, input logic [15:0] v);
    return {4'h3, d, 18'(v)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = ins(4'hF, 8'd0, 8'd0, 8'd0);
      rom2[i] = ins2(4'hF, 9'd0, 9'd0, 9'd0);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    exp_led_q.delete(); obs_led_q.delete(); exp_led2_q.delete(); obs_led2_q.delete();
    ip_trace_q.delete();
    led_prev = '0; led2_prev = '0;
    busy_cycles = 0; busy_seen = 1'b0; busy_ip_moved = 1'b0; busy_ip = '0;
    halt_cycles = 0; timed_out = 1'b0;
  endtask

  // Advances n cycles, sampling on the falling edge and recording observed behaviour.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge Clock);
      ip_trace_q.push_back(oIP);
      if (oLed !== led_prev) begin
        obs_led_q.push_back(oLed);
        led_prev = oLed;
      end
      if (oLed2 !== led2_prev) begin
        obs_led2_q.push_back(oLed2);
        led2_prev = oLed2;
      end
      if (oBusy) begin
        busy_cycles++;
        if (busy_seen && (oIP !== busy_ip)) busy_ip_moved = 1'b1;
        busy_seen = 1'b1;
        busy_ip   = oIP;
      end
    end
  endtask

  task automatic run_to_halt(input int budget);
    int k;
    k = 0;
    while (!(oHalted === 1'b1 && oHalted2 === 1'b1) && k < budget) begin
      run(1);
      k++;
    end
    halt_cycles = k;
    timed_out   = !(oHalted === 1'b1 && oHalted2 === 1'b1);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    tests_run++;
    if ({oIP, oLed, oBusy, oHalted} !== {16'd0, 8'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset.outputs: got ip=%h led=%h busy=%b halted=%b, required all zero", oIP, oLed, oBusy, oHalted);
    end
    tests_run++;
    if ({oIP2, oLed2, oBusy2, oHalted2} !== {16'd0, 8'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset.outputs2: got ip=%h led=%h busy=%b halted=%b, required all zero", oIP2, oLed2, oBusy2, oHalted2);
    end
  endtask

  task automatic test_add_led();
    logic [LW-1:0] e, o;
    clear_rom();
    rom[0] = sto(8'd1, 16'd5);
    rom[1] = sto(8'd2, 16'd3);
    rom[2] = ins(4'h4, 8'd3, 8'd2, 8'd1);
    rom[3] = ins(4'h1, 8'd0, 8'd3, 8'd0);
    rom[4] = ins(4'hB, 8'd3, 8'd1, 8'd1);
    do_reset();
    exp_led_q.push_back(8'h08);
    run_to_halt(100);
    run(3);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL add_led.timeout: got no halt, required halt within 100 cycles"); end
    while (exp_led_q.size() != 0) begin
      e = exp_led_q.pop_front();
      tests_run++;
      if (obs_led_q.size() == 0) begin tests_failed++; $display("FAIL add_led.led: got no update, required %h", e); end
      else begin
        o = obs_led_q.pop_front();
        if (o !== e) begin tests_failed++; $display("FAIL add_led.led: got %h, required %h", o, e); end
      end
    end
    tests_run++;
    if (obs_led_q.size() != 0) begin tests_failed++; $display("FAIL add_led.extra: got %0d extra led updates, required 0", obs_led_q.size()); end
    tests_run++;
    if (dut.rf_q[3] !== 16'h0008) begin tests_failed++; $display("FAIL add_led.r3: got %h, required 0008", dut.rf_q[3]); end
    tests_run++;
    if (halt_cycles != 7) begin tests_failed++; $display("FAIL add_led.halt_cycle: got %0d, required 7", halt_cycles); end
    tests_run++;
    if (oIP !== 16'd6) begin tests_failed++; $display("FAIL add_led.halt_ip: got %h, required 0006", oIP); end
  endtask

  task automatic test_smul();
    int a, b;
    logic [31:0] e0, e1;
    a = -3; b = 7;
    e0 = 32'(a * b);
    e1 = 32'(2 * a * b);
    clear_rom();
    rom[0] = sto(8'd1, 16'hFFFD);
    rom[1] = sto(8'd2, 16'd7);
    rom[2] = ins(4'h7, 8'd0, 8'd1, 8'd2);
    rom[3] = ins(4'h8, 8'd1, 8'd0, 8'd0);
    do_reset();
    run_to_halt(200);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL smul.timeout: got no halt, required halt within 200 cycles"); end
    tests_run++;
    if (busy_cycles != SMUL_BUSY) begin tests_failed++; $display("FAIL smul.busy_cycles: got %0d, required %0d", busy_cycles, SMUL_BUSY); end
    tests_run++;
    if (busy_ip_moved) begin tests_failed++; $display("FAIL smul.ip_stall: got ip moving while busy, required held"); end
    tests_run++;
    if (halt_cycles != 6 + (SMUL_BUSY > 0 ? SMUL_BUSY - 1 : 0)) begin
      tests_failed++; $display("FAIL smul.latency: got halt at %0d, required %0d", halt_cycles, 6 + (SMUL_BUSY > 0 ? SMUL_BUSY - 1 : 0));
    end
    tests_run++;
    if (dut.wrf_q[0] !== e0) begin tests_failed++; $display("FAIL smul.w0: got %h, required %h", dut.wrf_q[0], e0); end
    tests_run++;
    if (dut.wrf_q[1] !== e1) begin tests_failed++; $display("FAIL smul.w1: got %h, required %h", dut.wrf_q[1], e1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e2, e3, e4;
    logic [LW-1:0] e, o;
    e2 = 32'(32768 * 32768);
    e3 = 32'(32767 * -3);
    e4 = e3 - e2;
    clear_rom();
    rom[0] = sto(8'd3, 16'h8000);
    rom[1] = sto(8'd4, 16'h7FFF);
    rom[2] = sto(8'd1, 16'hFFFD);
    rom[3] = ins(4'h7, 8'd2, 8'd3, 8'd3);
    rom[4] = ins(4'h7, 8'd3, 8'd4, 8'd1);
    rom[5] = ins(4'h9, 8'd4, 8'd3, 8'd2);
    rom[6] = ins(4'h1, 8'd0, 8'd4, 8'd0);
    do_reset();
    exp_led_q.push_back(8'hFF);
    run_to_halt(300);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL b2b.timeout: got no halt, required halt within 300 cycles"); end
    tests_run++;
    if (busy_cycles != 2 * SMUL_BUSY) begin tests_failed++; $display("FAIL b2b.busy_cycles: got %0d, required %0d", busy_cycles, 2 * SMUL_BUSY); end
    tests_run++;
    if (dut.wrf_q[2] !== e2) begin tests_failed++; $display("FAIL b2b.w2: got %h, required %h", dut.wrf_q[2], e2); end
    tests_run++;
    if (dut.wrf_q[3] !== e3) begin tests_failed++; $display("FAIL b2b.w3: got %h, required %h", dut.wrf_q[3], e3); end
    tests_run++;
    if (dut.wrf_q[4] !== e4) begin tests_failed++; $display("FAIL b2b.w4: got %h, required %h", dut.wrf_q[4], e4); end
    while (exp_led_q.size() != 0) begin
      e = exp_led_q.pop_front();
      tests_run++;
      if (obs_led_q.size() == 0) begin tests_failed++; $display("FAIL b2b.led: got no update, required %h", e); end
      else begin
        o = obs_led_q.pop_front();
        if (o !== e) begin tests_failed++; $display("FAIL b2b.led: got %h, required %h", o, e); end
      end
    end
  endtask

  task automatic test_loop();
    logic [LW-1:0] e, o;
    clear_rom();
    rom[0] = sto(8'd1, 16'd0);
    rom[1] = sto(8'd2, 16'd1);
    rom[2] = sto(8'd3, 16'd4);
    rom[3] = ins(4'h4, 8'd1, 8'd1, 8'd2);
    rom[4] = ins(4'h2, 8'd3, 8'd1, 8'd3);
    rom[5] = ins(4'h1, 8'd0, 8'd1, 8'd0);
    do_reset();
    exp_led_q.push_back(8'h05);
    run_to_halt(200);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL loop.timeout: got no halt, required halt within 200 cycles"); end
    while (exp_led_q.size() != 0) begin
      e = exp_led_q.pop_front();
      tests_run++;
      if (obs_led_q.size() == 0) begin tests_failed++; $display("FAIL loop.led: got no update, required %h", e); end
      else begin
        o = obs_led_q.pop_front();
        if (o !== e) begin tests_failed++; $display("FAIL loop.led: got %h, required %h", o, e); end
      end
    end
    tests_run++;
    if (obs_led_q.size() != 0) begin tests_failed++; $display("FAIL loop.squash: got %0d extra led updates, required 0", obs_led_q.size()); end
    tests_run++;
    if (dut.rf_q[1] !== 16'd5) begin tests_failed++; $display("FAIL loop.r1: got %h, required 0005", dut.rf_q[1]); end
  endtask

  task automatic test_branch_halt();
    int exp_ip[10];
    exp_ip = '{1, 2, 3, 4, 10, 11, 12, 13, 13, 13};
    clear_rom();
    rom[0]  = sto(8'd5, 16'h1234);
    rom[1]  = sto(8'd6, 16'h1234);
    rom[2]  = sto(8'd7, 16'h1235);
    rom[3]  = ins(4'hA, 8'd10, 8'd5, 8'd6);
    rom[4]  = sto(8'd8, 16'h00EE);
    rom[10] = ins(4'hA, 8'd20, 8'd5, 8'd7);
    rom[11] = ins(4'h1, 8'd0, 8'd5, 8'd0);
    rom[13] = ins(4'h5, 8'd0, 8'd0, 8'd0);
    do_reset();
    run_to_halt(100);
    run(3);
    tests_run++;
    if (ip_trace_q.size() < 10) begin
      tests_failed++; $display("FAIL branch.trace_len: got %0d samples, required at least 10", ip_trace_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (i > 0) tests_run++;
        if (ip_trace_q[i] !== 16'(exp_ip[i])) begin
          tests_failed++; $display("FAIL branch.ip[%0d]: got %h, required %h", i, ip_trace_q[i], 16'(exp_ip[i]));
        end
      end
    end
    tests_run++;
    if (dut.rf_q[8] !== 16'd0) begin tests_failed++; $display("FAIL branch.squash_r8: got %h, required 0000", dut.rf_q[8]); end
    tests_run++;
    if (oLed !== 8'h34) begin tests_failed++; $display("FAIL branch.led: got %h, required 34", oLed); end
    tests_run++;
    if (oHalted !== 1'b1 || oIP !== 16'd13) begin tests_failed++; $display("FAIL halt.frozen: got halted=%b ip=%h, required 1 and 000d", oHalted, oIP); end
  endtask

  task automatic test_reset_mid_smul();
    clear_rom();
    rom[0] = sto(8'd1, 16'd5);
    rom[1] = sto(8'd2, 16'd6);
    rom[2] = ins(4'h1, 8'd0, 8'd1, 8'd0);
    rom[3] = ins(4'h7, 8'd4, 8'd1, 8'd2);
    do_reset();
    run(9);
    tests_run++;
    if (oBusy !== (SMUL_BUSY > 0) || oLed !== 8'h05) begin
      tests_failed++; $display("FAIL mid_smul.pre: got busy=%b led=%h, required %b and 05", oBusy, oLed, SMUL_BUSY > 0);
    end
    Reset = 1'b1;
    #1;
    tests_run++;
    if ({oBusy, oIP, oLed, oHalted} !== {1'b0, 16'd0, 8'd0, 1'b0}) begin
      tests_failed++; $display("FAIL mid_smul.async: got busy=%b ip=%h led=%h halted=%b, required all zero", oBusy, oIP, oLed, oHalted);
    end
    clear_rom();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    run(25);
    tests_run++;
    if (dut.wrf_q[4] !== 32'd0) begin tests_failed++; $display("FAIL mid_smul.w4: got %h, required 00000000", dut.wrf_q[4]); end
  endtask

  task automatic test_out_of_range();
    logic [LW-1:0] e, o;
    int bad;
    clear_rom();
    rom2[0] = sto2(9'd1, 16'h0011);
    rom2[1] = ins2(4'h1, 9'd0, 9'd1, 9'd0);
    rom2[2] = sto2(9'd300, 16'h0055);
    rom2[3] = ins2(4'h1, 9'd0, 9'd300, 9'd0);
    do_reset();
    exp_led2_q.push_back(8'h11);
    exp_led2_q.push_back(8'h00);
    run_to_halt(100);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL oor.timeout: got no halt, required halt within 100 cycles"); end
    while (exp_led2_q.size() != 0) begin
      e = exp_led2_q.pop_front();
      tests_run++;
      if (obs_led2_q.size() == 0) begin tests_failed++; $display("FAIL oor.led: got no update, required %h", e); end
      else begin
        o = obs_led2_q.pop_front();
        if (o !== e) begin tests_failed++; $display("FAIL oor.led: got %h, required %h", o, e); end
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut2.rf_q[i] !== ((i == 1) ? 16'h0011 : 16'h0000)) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL oor.regfile: got %0d unexpected registers, required 0", bad); end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_add_led();
    test_smul();
    test_back_to_back();
    test_loop();
    test_branch_halt();
    test_reset_mid_smul();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
